// File: rtl/obi_host_arbiter.sv
// Two-host OBI arbiter: shares one 64-bit device port between instruction fetch (h0) and LSU (h1),
// locks the address phase across device stalls and returns responses in issue order.
module obi_host_arbiter #(
  parameter bit          RR_EN   = 1'b0,
  parameter int unsigned MAX_OUT = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        h0_req_i,
  input  logic        h0_we_i,
  input  logic [7:0]  h0_be_i,
  input  logic [63:0] h0_addr_i,
  input  logic [63:0] h0_wdata_i,
  output logic        h0_gnt_o,
  output logic        h0_rvalid_o,
  output logic [63:0] h0_rdata_o,
  input  logic        h1_req_i,
  input  logic        h1_we_i,
  input  logic [7:0]  h1_be_i,
  input  logic [63:0] h1_addr_i,
  input  logic [63:0] h1_wdata_i,
  output logic        h1_gnt_o,
  output logic        h1_rvalid_o,
  output logic [63:0] h1_rdata_o,
  output logic        d_req_o,
  output logic        d_we_o,
  output logic [7:0]  d_be_o,
  output logic [63:0] d_addr_o,
  output logic [63:0] d_wdata_o,
  input  logic        d_gnt_i,
  input  logic        d_rvalid_i,
  input  logic [63:0] d_rdata_i,
  output logic        err_o
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  typedef struct packed {
    logic        we;
    logic [7:0]  be;
    logic [63:0] addr;
    logic [63:0] wdata;
  } hreq_t;

  hreq_t [1:0] hreq;
  logic  [1:0] hreq_v;
  logic  [1:0] gnt, rvalid;

  logic               rst_q;
  logic               lock_q, lock_id_q;
  logic               last_q;
  logic               err_q;
  logic [CW-1:0]      cnt_q;
  logic [PW-1:0]      rd_q, wr_q;
  logic [MAX_OUT-1:0] ids_q;

  logic sel, full, acc, pop, head;

  assign hreq[0] = '{we: h0_we_i, be: h0_be_i, addr: h0_addr_i, wdata: h0_wdata_i};
  assign hreq[1] = '{we: h1_we_i, be: h1_be_i, addr: h1_addr_i, wdata: h1_wdata_i};
  assign hreq_v  = {h1_req_i, h0_req_i};

  function automatic logic [PW-1:0] ptr_nxt(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUT - 1)) ? '0 : p + PW'(1);
  endfunction

  // A waiting request keeps the port: no re-arbitration until it is granted.
  always_comb begin
    sel = 1'b0;
    if (lock_q)               sel = lock_id_q;
    else if (hreq_v == 2'b11) sel = RR_EN ? ~last_q : 1'b1;
    else                      sel = hreq_v[1];
  end

  assign full = (cnt_q == CW'(MAX_OUT));
  // rst_q masks the cycle right after reset so nothing issues or routes then.
  assign d_req_o   = hreq_v[sel] & ~full & ~rst_i & ~rst_q;
  assign d_we_o    = hreq[sel].we;
  assign d_be_o    = hreq[sel].be;
  assign d_addr_o  = hreq[sel].addr;
  assign d_wdata_o = hreq[sel].wdata;

  assign acc  = d_req_o & d_gnt_i;
  assign pop  = d_rvalid_i & (cnt_q != '0) & ~rst_i;
  assign head = ids_q[rd_q];

  for (genvar n = 0; n < 2; n++) begin : g_host
    assign gnt[n]    = acc & (sel == 1'(n));
    assign rvalid[n] = pop & (head == 1'(n));
  end

  assign h0_gnt_o    = gnt[0];
  assign h1_gnt_o    = gnt[1];
  assign h0_rvalid_o = rvalid[0];
  assign h1_rvalid_o = rvalid[1];
  assign h0_rdata_o  = d_rdata_i;
  assign h1_rdata_o  = d_rdata_i;
  assign err_o       = err_q;

  always_ff @(posedge clk_i) begin
    rst_q <= rst_i;
    if (rst_i) begin
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
      last_q    <= 1'b1;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      rd_q      <= '0;
      wr_q      <= '0;
      ids_q     <= '0;
    end else begin
      if (acc) begin
        ids_q[wr_q] <= sel;
        wr_q        <= ptr_nxt(wr_q);
      end
      if (pop) rd_q <= ptr_nxt(rd_q);
      case ({acc, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (acc) begin
        lock_q <= 1'b0;
      end else if (d_req_o) begin
        lock_q    <= 1'b1;
        lock_id_q <= sel;
      end
      if (RR_EN && acc) last_q <= sel;
      // Responses arriving in the post-reset cycle are dropped silently.
      if (d_rvalid_i && (cnt_q == '0) && !rst_q) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_obi_host_arbiter.sv
// Bench for obi_host_arbiter: a fixed-priority and a round-robin instance share directed stimulus
// and are compared every cycle against a queue-based model, plus literal expectations.
module tb_obi_host_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        h0_req, h1_req, h0_we, h1_we, d_gnt, d_rvalid;
  logic [7:0]  h0_be, h1_be;
  logic [63:0] h0_addr, h1_addr, h0_wdata, h1_wdata, d_rdata;

  logic        d_req [2], d_we [2], h0_gnt [2], h1_gnt [2], h0_rv [2], h1_rv [2], err [2];
  logic [7:0]  d_be [2];
  logic [63:0] d_addr [2], d_wdata [2], h0_rdata [2], h1_rdata [2];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    obi_host_arbiter #(.RR_EN(k == 1), .MAX_OUT(2)) dut (
      .clk_i(clk), .rst_i(rst),
      .h0_req_i(h0_req), .h0_we_i(h0_we), .h0_be_i(h0_be), .h0_addr_i(h0_addr),
      .h0_wdata_i(h0_wdata), .h0_gnt_o(h0_gnt[k]), .h0_rvalid_o(h0_rv[k]), .h0_rdata_o(h0_rdata[k]),
      .h1_req_i(h1_req), .h1_we_i(h1_we), .h1_be_i(h1_be), .h1_addr_i(h1_addr),
      .h1_wdata_i(h1_wdata), .h1_gnt_o(h1_gnt[k]), .h1_rvalid_o(h1_rv[k]), .h1_rdata_o(h1_rdata[k]),
      .d_req_o(d_req[k]), .d_we_o(d_we[k]), .d_be_o(d_be[k]), .d_addr_o(d_addr[k]),
      .d_wdata_o(d_wdata[k]), .d_gnt_i(d_gnt), .d_rvalid_i(d_rvalid), .d_rdata_i(d_rdata),
      .err_o(err[k])
    );
  end

  // ---------------- behavioural model ----------------
  bit mq0[$], mq1[$];
  bit m_lock [2], m_lid [2], m_last [2], m_err [2];
  bit m_rstq  = 1'b0;
  bit started = 1'b0;

  function automatic int qsize(int k);
    return (k == 1) ? mq1.size() : mq0.size();
  endfunction
  function automatic bit qhead(int k);
    return (k == 1) ? mq1[0] : mq0[0];
  endfunction
  function automatic bit m_sel(int k);
    if (m_lock[k]) return m_lid[k];
    if (h0_req && h1_req) return (k == 1) ? ~m_last[k] : 1'b1;
    return h1_req;
  endfunction
  function automatic bit m_dreq(int k);
    return (m_sel(k) ? h1_req : h0_req) && (qsize(k) < 2) && !rst && !m_rstq;
  endfunction
  function automatic bit m_rv(int k, bit n);
    return d_rvalid && !rst && (qsize(k) != 0) && (qhead(k) == n);
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit s, dr;
      s  = m_sel(k);
      dr = m_dreq(k);
      if (rst) begin
        if (k == 1) mq1.delete(); else mq0.delete();
        m_lock[k] = 1'b0; m_lid[k] = 1'b0; m_last[k] = 1'b1; m_err[k] = 1'b0;
      end else begin
        if (d_rvalid) begin
          if (qsize(k) != 0) begin
            if (k == 1) void'(mq1.pop_front()); else void'(mq0.pop_front());
          end else if (!m_rstq) m_err[k] = 1'b1;
        end
        if (dr && d_gnt) begin
          if (k == 1) mq1.push_back(s); else mq0.push_back(s);
          m_lock[k] = 1'b0;
          if (k == 1) m_last[k] = s;
        end else if (dr) begin
          m_lock[k] = 1'b1; m_lid[k] = s;
        end
      end
    end
    m_rstq  = rst;
    started = 1'b1;
  end

  // ---------------- literal expectations posted by the stimulus ----------------
  localparam int S_DREQ = 0, S_DADDR = 1, S_H0GNT = 2, S_H1GNT = 3, S_H0RV = 4, S_H1RV = 5;
  localparam int S_ERR = 6, S_RDATA0 = 7;
  string       lit_nm [256];
  int          lit_k [256], lit_sig [256];
  logic [63:0] lit_v [256];
  int          lit_n = 0;

  function automatic logic [63:0] sig_val(int k, int s);
    case (s)
      S_DREQ:  return 64'(d_req[k]);
      S_DADDR: return d_addr[k];
      S_H0GNT: return 64'(h0_gnt[k]);
      S_H1GNT: return 64'(h1_gnt[k]);
      S_H0RV:  return 64'(h0_rv[k]);
      S_H1RV:  return 64'(h1_rv[k]);
      S_ERR:   return 64'(err[k]);
      default: return h0_rdata[k];
    endcase
  endfunction

  task automatic lit(string nm, int k, int s, logic [63:0] v);
    lit_nm[lit_n] = nm; lit_k[lit_n] = k; lit_sig[lit_n] = s; lit_v[lit_n] = v;
    lit_n++;
  endtask
  task automatic lit2(string nm, int s, logic [63:0] v);
    lit(nm, 0, s, v);
    lit(nm, 1, s, v);
  endtask

  // ---------------- compare process ----------------
  int checks = 0, failures = 0, lit_rd = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        bit s, dr;
        s  = m_sel(k);
        dr = m_dreq(k);
        chk($sformatf("u%0d.d_req", k),    64'(d_req[k]), 64'(dr));
        chk($sformatf("u%0d.d_addr", k),   d_addr[k],  s ? h1_addr : h0_addr);
        chk($sformatf("u%0d.d_wdata", k),  d_wdata[k], s ? h1_wdata : h0_wdata);
        chk($sformatf("u%0d.d_we_be", k),  {55'd0, d_we[k], d_be[k]},
            {55'd0, s ? h1_we : h0_we, s ? h1_be : h0_be});
        chk($sformatf("u%0d.h0_gnt", k),   64'(h0_gnt[k]), 64'(dr && d_gnt && !s));
        chk($sformatf("u%0d.h1_gnt", k),   64'(h1_gnt[k]), 64'(dr && d_gnt && s));
        chk($sformatf("u%0d.h0_rvalid", k), 64'(h0_rv[k]), 64'(m_rv(k, 1'b0)));
        chk($sformatf("u%0d.h1_rvalid", k), 64'(h1_rv[k]), 64'(m_rv(k, 1'b1)));
        chk($sformatf("u%0d.rdata", k),    h0_rdata[k] ^ h1_rdata[k] ^ d_rdata, d_rdata);
        chk($sformatf("u%0d.err", k),      64'(err[k]), 64'(m_err[k]));
      end
    end
    while (lit_rd < lit_n) begin
      chk($sformatf("u%0d.%s", lit_k[lit_rd], lit_nm[lit_rd]),
          sig_val(lit_k[lit_rd], lit_sig[lit_rd]), lit_v[lit_rd]);
      lit_rd++;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    h0_req = 0; h1_req = 0; d_gnt = 0; d_rvalid = 0;
  endtask
  task automatic reset_seq();
    cyc(); idle(); rst = 1;
    cyc(); rst = 0;
  endtask

  initial begin
    rst = 1; idle();
    h0_we = 0; h1_we = 1; h0_be = 8'hFF; h1_be = 8'h0F;
    h0_addr = 64'h1000; h1_addr = 64'h2000; h0_wdata = 64'h0; h1_wdata = 64'hA5A5_0000_1111_2222;
    d_rdata = '0;
    cyc(); cyc();
    // post-reset cycle: request blocked
    rst = 0; h0_req = 1; d_gnt = 1;
    lit2("post_rst_dreq", S_DREQ, 0); lit2("post_rst_gnt", S_H0GNT, 0); lit2("rst_err", S_ERR, 0);

    // single read from h0
    cyc(); lit2("rd_h0_gnt", S_H0GNT, 1); lit2("rd_addr", S_DADDR, 64'h1000);
    cyc(); idle(); d_rvalid = 1; d_rdata = 64'hDEADBEEF;
    lit2("rd_h0_rv", S_H0RV, 1); lit2("rd_h1_rv", S_H1RV, 0); lit2("rd_data", S_RDATA0, 64'hDEADBEEF);
    cyc(); idle();

    // contention
    reset_seq();
    for (int i = 0; i < 4; i++) begin
      cyc(); h0_req = 1; h1_req = 1; d_gnt = 1; d_rvalid = (i != 0); d_rdata = 64'(i);
      lit("ct_gnt_h1", 0, S_H1GNT, 1); lit("ct_gnt_h0", 0, S_H0GNT, 0);
      lit("rr_gnt_h0", 1, S_H0GNT, (i % 2 == 0)); lit("rr_gnt_h1", 1, S_H1GNT, (i % 2 == 1));
      lit("rr_addr", 1, S_DADDR, (i % 2 == 0) ? 64'h1000 : 64'h2000);
      if (i != 0) begin
        lit("ct_rv_h1", 0, S_H1RV, 1);
        lit("rr_rv_h0", 1, S_H0RV, (i % 2 == 1)); lit("rr_rv_h1", 1, S_H1RV, (i % 2 == 0));
      end
    end
    cyc(); idle(); d_rvalid = 1;
    lit("ct_rv_last", 0, S_H1RV, 1); lit("rr_rv_last", 1, S_H1RV, 1);
    cyc(); idle();

    // lock across device stall
    reset_seq();
    cyc(); h0_req = 1; d_gnt = 0;
    lit2("lk_dreq", S_DREQ, 1); lit2("lk_addr0", S_DADDR, 64'h1000);
    for (int i = 0; i < 2; i++) begin
      cyc(); h1_req = 1;
      lit2("lk_addr_hold", S_DADDR, 64'h1000); lit2("lk_no_gnt1", S_H1GNT, 0);
    end
    cyc(); d_gnt = 1; lit2("lk_gnt_h0", S_H0GNT, 1); lit2("lk_no_gnt1b", S_H1GNT, 0);
    cyc(); h0_req = 0; lit2("lk_gnt_h1", S_H1GNT, 1); lit2("lk_addr1", S_DADDR, 64'h2000);
    cyc(); idle(); d_rvalid = 1; lit2("lk_rv_h0", S_H0RV, 1);
    cyc(); d_rvalid = 1; lit2("lk_rv_h1", S_H1RV, 1);
    cyc(); idle();

    // full at MAX_OUT=2
    reset_seq();
    cyc(); h0_req = 1; d_gnt = 1; h0_addr = 64'h1000; lit2("fl_gnt1", S_H0GNT, 1);
    cyc(); h0_addr = 64'h1008; lit2("fl_gnt2", S_H0GNT, 1);
    cyc(); h0_addr = 64'h3000;
    lit2("fl_blocked", S_DREQ, 0); lit2("fl_no_gnt", S_H0GNT, 0); lit2("fl_addr", S_DADDR, 64'h3000);
    cyc(); d_rvalid = 1; lit2("fl_pop_noreq", S_DREQ, 0); lit2("fl_pop_rv", S_H0RV, 1);
    cyc(); d_rvalid = 0; lit2("fl_issue", S_DREQ, 1); lit2("fl_gnt3", S_H0GNT, 1);
    cyc(); idle(); d_rvalid = 1; lit2("fl_rv2", S_H0RV, 1);
    cyc(); d_rvalid = 1; lit2("fl_rv3", S_H0RV, 1);
    cyc(); idle(); h0_addr = 64'h1000;

    // stray response, then reset mid-flight
    cyc(); d_rvalid = 1; lit2("er_rv0", S_H0RV, 0); lit2("er_rv1", S_H1RV, 0);
    cyc(); d_rvalid = 0; lit2("er_set", S_ERR, 1);
    cyc(); h1_req = 1; d_gnt = 1; lit2("er_g1", S_H1GNT, 1);
    cyc(); lit2("er_g2", S_H1GNT, 1);
    cyc(); idle(); rst = 1; d_rvalid = 1;
    lit2("rs_rv0", S_H0RV, 0); lit2("rs_rv1", S_H1RV, 0); lit2("rs_dreq", S_DREQ, 0);
    cyc(); rst = 0; d_rvalid = 1;
    lit2("rs_err_clr", S_ERR, 0); lit2("rs_drop_rv", S_H1RV, 0);
    cyc(); d_rvalid = 1; lit2("rs_stray_rv", S_H1RV, 0); lit2("rs_err_still0", S_ERR, 0);
    cyc(); d_rvalid = 0; lit2("rs_err_set", S_ERR, 1);
    cyc(); idle();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
